axis_fifo: RTL and testbench
============================

Name: axis_fifo

Overview:
Parametrised AXI4-Stream synchronous FIFO with a slave (S_) and a master (M_) port. It carries the full sideband set: TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER. It generalises the team's source-to-sink harness into real buffering, with configurable width, depth and packet mode. The AXI4-Stream source and sink checkers bind onto its two ports in formal runs.

Parameters:
DATA_BYTES, 4, TDATA width in bytes; TSTRB and TKEEP are DATA_BYTES bits wide.
ID_WIDTH, 4, TID width.
DEST_WIDTH, 4, TDEST width.
USER_WIDTH, 8, TUSER width.
DEPTH, 8, number of entries; power of two, at least 2.

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
S_TDATA/S_TSTRB/S_TKEEP/S_TLAST/S_TID/S_TDEST/S_TUSER  in  per parameters  slave beat
S_TVALID  in  1  slave valid
S_TREADY  out  1  slave ready
M_TDATA/M_TSTRB/M_TKEEP/M_TLAST/M_TID/M_TDEST/M_TUSER  out  per parameters  master beat
M_TVALID  out  1  master valid
M_TREADY  in  1  master ready
LEVEL  out  $clog2(DEPTH+1)  stored beat count

Behaviour:
- Reset: one clock (ACLK); asynchronous, active-low reset (ARESETn).
  - While ARESETn=0: pointers=0, LEVEL=0, M_TVALID=0, S_TREADY=0, M_* payload=0.
- After reset release: S_TREADY rises on the first ACLK edge.
- Push: when S_TVALID&&S_TREADY, write the whole beat at wr_ptr and increment wr_ptr.
- Pop: when M_TVALID&&M_TREADY, increment rd_ptr.
- Pointers: log2(DEPTH)+1 bits each, with wrap bit.
  - full = pointer MSBs differ and the rest equal.
  - empty = pointers equal.
- LEVEL = wr_ptr-rd_ptr, modulo pointer width.
- S_TREADY = !full, registered. It is driven from next-state, so there are no combinational paths from S_TVALID or M_TREADY to S_TREADY.
- M_* is driven from a registered output stage: first-word fall-through with one cycle of latency.
  - A beat accepted in cycle N appears on M_* with M_TVALID=1 in cycle N+1 if the FIFO was empty.
- Stability: while M_TVALID=1 and M_TREADY=0, every M_* signal holds stable and M_TVALID does not deassert.
- Simultaneous push and pop:
  - not full, not empty: LEVEL unchanged.
  - empty: the pushed beat is still registered first; no same-cycle pass-through.
  - full: no push (S_TREADY=0); the pop frees a slot and S_TREADY=1 next cycle.
- Ordering: beats leave in arrival order. TLAST and the sidebands are never altered or reordered.
- Reset mid-transfer: all stored beats are discarded. Outputs go to their reset values asynchronously.

Optional Feature:
Macro AXIS_FIFO_PACKET_MODE_EN.
- Defined: store-and-forward.
  - A packet counter increments when a TLAST beat is pushed and decrements when a TLAST beat is popped.
  - M_TVALID asserts only when packet counter>0 or the FIFO is full.
  - The full escape releases an oversized packet cut-through and avoids deadlock.
  - A packet already being released continues until its TLAST regardless of counter.
- Undefined: cut-through as above; no packet counter logic is built.

Decomposition:
- Add to amba_axi4_stream_seda_pkg:
  - an axis_beat_t packed struct (data, strb, keep, last, id, dest, user);
  - width-derivation functions;
  - a DEPTH power-of-two check.
- One sub-module, axis_fifo_mem: DEPTH×beat storage with write port and registered read port.
- Pointer, flag and output-stage control stays in axis_fifo.

Test Plan:
- Reset, then single beat:
  - stimulus: TDATA=0xA5A5_0001, TLAST=1, TID=3, pushed in cycle 0;
  - response: M_TVALID=1 in cycle 1 with identical fields; LEVEL=1; after pop, LEVEL=0 and M_TVALID=0.
- Fill: push 8 beats (values 0..7) with M_TREADY=0.
  - S_TREADY=0 after the 8th push; LEVEL=8.
  - M_TDATA holds at 0 across 20 stall cycles.
- Full plus simultaneous push/pop: with LEVEL=8, M_TREADY=1 for one cycle.
  - beat 0 pops; S_TREADY=1 next cycle; the next push lands without loss.
  - 1000 random push/pop beats return data in order and wrap pointers more than 100 times.
- Reset mid-stream: ARESETn=0 with LEVEL=5.
  - M_TVALID=0 and S_TREADY=0 immediately, without waiting for a clock edge.
  - After release: LEVEL=0; the first new beat is the first output.
- Packet mode (macro defined): push a 3-beat packet with TLAST on beat 3.
  - M_TVALID stays 0 until the cycle after beat 3 is pushed; then 3 beats in order.
  - A 10-beat packet: release starts when LEVEL=8 and completes.
- Formal: bind the AXI4-Stream source checker on the M_ port and the sink checker on the S_ port; all assertions prove and cover traces are reached.

Source files
------------

// File: rtl/amba_axi4_stream_seda_pkg.sv
// Shared AXI4-Stream definitions: default beat layout, width derivation
// helpers and the FIFO depth legality check used by axis_fifo.
package amba_axi4_stream_seda_pkg;

    localparam int AXIS_DATA_BYTES = 4;
    localparam int AXIS_ID_WIDTH   = 4;
    localparam int AXIS_DEST_WIDTH = 4;
    localparam int AXIS_USER_WIDTH = 8;

    // Beat layout at the default widths; axis_fifo mirrors this field order
    // for its own parameterised widths so both pack identically.
    typedef struct packed {
        logic [8*AXIS_DATA_BYTES-1:0] data;
        logic [AXIS_DATA_BYTES-1:0]   strb;
        logic [AXIS_DATA_BYTES-1:0]   keep;
        logic                         last;
        logic [AXIS_ID_WIDTH-1:0]     id;
        logic [AXIS_DEST_WIDTH-1:0]   dest;
        logic [AXIS_USER_WIDTH-1:0]   user;
    } axis_beat_t;

    function automatic int tdata_width(input int data_bytes);
        return 8 * data_bytes;
    endfunction

    // data + strb + keep + last + id + dest + user
    function automatic int beat_width(input int data_bytes, input int id_w,
                                      input int dest_w, input int user_w);
        return 10 * data_bytes + 1 + id_w + dest_w + user_w;
    endfunction

    // One extra wrap bit distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit depth_is_pow2(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Beat storage for axis_fifo: DEPTH x WIDTH array with one write port and a
// registered read port. A read of the entry being written in the same cycle
// returns the incoming word (write-first), so the caller never needs a bypass.
module axis_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    // Storage array; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read data select with write-first forwarding on an address collision.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
        end
    end

    // Read register; cleared by reset because it drives the M_ payload directly.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axis_fifo.sv
// AXI4-Stream synchronous FIFO with registered first-word-fall-through output.
// LEVEL counts every stored beat including the one presented on M_*.
// Define AXIS_FIFO_PACKET_MODE_EN for store-and-forward; otherwise cut-through.
module axis_fifo
    import amba_axi4_stream_seda_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int ID_WIDTH   = 4,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                            ACLK,
    input  logic                            ARESETn,
    input  logic [8*DATA_BYTES-1:0]         S_TDATA,
    input  logic [DATA_BYTES-1:0]           S_TSTRB,
    input  logic [DATA_BYTES-1:0]           S_TKEEP,
    input  logic                            S_TLAST,
    input  logic [ID_WIDTH-1:0]             S_TID,
    input  logic [DEST_WIDTH-1:0]           S_TDEST,
    input  logic [USER_WIDTH-1:0]           S_TUSER,
    input  logic                            S_TVALID,
    output logic                            S_TREADY,
    output logic [8*DATA_BYTES-1:0]         M_TDATA,
    output logic [DATA_BYTES-1:0]           M_TSTRB,
    output logic [DATA_BYTES-1:0]           M_TKEEP,
    output logic                            M_TLAST,
    output logic [ID_WIDTH-1:0]             M_TID,
    output logic [DEST_WIDTH-1:0]           M_TDEST,
    output logic [USER_WIDTH-1:0]           M_TUSER,
    output logic                            M_TVALID,
    input  logic                            M_TREADY,
    output logic [$clog2(DEPTH+1)-1:0]      LEVEL
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);
    localparam int LW = level_width(DEPTH);
    localparam int BW = beat_width(DATA_BYTES, ID_WIDTH, DEST_WIDTH, USER_WIDTH);

    if (!depth_is_pow2(DEPTH)) begin : g_bad_depth
        $error("axis_fifo: DEPTH must be a power of two and at least 2");
    end

    typedef struct packed {
        logic [tdata_width(DATA_BYTES)-1:0] data;
        logic [DATA_BYTES-1:0]              strb;
        logic [DATA_BYTES-1:0]              keep;
        logic                               last;
        logic [ID_WIDTH-1:0]                id;
        logic [DEST_WIDTH-1:0]              dest;
        logic [USER_WIDTH-1:0]              user;
    } beat_t;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          s_ready_q, s_ready_d;
    logic          m_valid_q, m_valid_d;
    logic          push, pop, full_d, nonempty_d, release_ok, load;
    beat_t         s_beat, m_beat;
    logic [BW-1:0] rdata;

    assign push = S_TVALID && s_ready_q;
    assign pop  = m_valid_q && M_TREADY;

    assign s_beat = '{data: S_TDATA, strb: S_TSTRB, keep: S_TKEEP, last: S_TLAST,
                      id: S_TID, dest: S_TDEST, user: S_TUSER};

    // Pointer next-state and the flags derived from it; S_TREADY is the
    // registered complement of next-cycle full, so it has no path from inputs.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        full_d     = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                     (wr_ptr_d[PW-2:0] == rd_ptr_d[PW-2:0]);
        nonempty_d = (wr_ptr_d != rd_ptr_d);
        s_ready_d  = !full_d;
    end

`ifdef AXIS_FIFO_PACKET_MODE_EN
    logic [LW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic          rel_q, rel_d;

    // Complete-packet count and in-release tracking; a packet that has started
    // leaving keeps flowing until its TLAST, and a full FIFO forces release.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (push && S_TLAST) pkt_cnt_d = pkt_cnt_d + LW'(1);
        if (pop && M_TLAST)  pkt_cnt_d = pkt_cnt_d - LW'(1);
        rel_d = rel_q;
        if (pop) rel_d = !M_TLAST;
        release_ok = (pkt_cnt_d != '0) || full_d || rel_d;
    end

    // Packet-mode control registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            pkt_cnt_q <= '0;
            rel_q     <= 1'b0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
            rel_q     <= rel_d;
        end
    end
`else
    assign release_ok = 1'b1;
`endif

    // Output stage reloads when it is empty or being drained and the oldest
    // stored beat (at the next read pointer) may be released.
    always_comb begin
        load      = (!m_valid_q || pop) && nonempty_d && release_ok;
        m_valid_d = (m_valid_q && !pop) || load;
    end

    // Pointer, ready and valid registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
        end
    end

    axis_fifo_mem #(
        .WIDTH (BW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (ACLK),
        .rst_n_i (ARESETn),
        .we_i    (push),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (s_beat),
        .re_i    (load),
        .raddr_i (rd_ptr_d[AW-1:0]),
        .rdata_o (rdata)
    );

    assign m_beat   = beat_t'(rdata);
    assign M_TDATA  = m_beat.data;
    assign M_TSTRB  = m_beat.strb;
    assign M_TKEEP  = m_beat.keep;
    assign M_TLAST  = m_beat.last;
    assign M_TID    = m_beat.id;
    assign M_TDEST  = m_beat.dest;
    assign M_TUSER  = m_beat.user;
    assign M_TVALID = m_valid_q;
    assign S_TREADY = s_ready_q;
    assign LEVEL    = LW'(wr_ptr_q - rd_ptr_q);

endmodule

// File: tb/tb_axis_fifo.sv
// Directed bench for axis_fifo at default parameters (DATA_BYTES=4, DEPTH=8).
module tb_axis_fifo;

    logic        ACLK;
    logic        ARESETn;
    logic [31:0] S_TDATA;
    logic [3:0]  S_TSTRB, S_TKEEP, S_TID, S_TDEST;
    logic        S_TLAST, S_TVALID, S_TREADY;
    logic [7:0]  S_TUSER;
    logic [31:0] M_TDATA;
    logic [3:0]  M_TSTRB, M_TKEEP, M_TID, M_TDEST;
    logic        M_TLAST, M_TVALID, M_TREADY;
    logic [7:0]  M_TUSER;
    logic [3:0]  LEVEL;

    int checks = 0;
    int errors = 0;

    axis_fifo dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .S_TDATA(S_TDATA), .S_TSTRB(S_TSTRB), .S_TKEEP(S_TKEEP), .S_TLAST(S_TLAST),
        .S_TID(S_TID), .S_TDEST(S_TDEST), .S_TUSER(S_TUSER),
        .S_TVALID(S_TVALID), .S_TREADY(S_TREADY),
        .M_TDATA(M_TDATA), .M_TSTRB(M_TSTRB), .M_TKEEP(M_TKEEP), .M_TLAST(M_TLAST),
        .M_TID(M_TID), .M_TDEST(M_TDEST), .M_TUSER(M_TUSER),
        .M_TVALID(M_TVALID), .M_TREADY(M_TREADY),
        .LEVEL(LEVEL)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_beat(input logic [31:0] d, input logic l, input logic [3:0] id,
                            input logic [3:0] dst, input logic [7:0] u);
        S_TDATA = d; S_TLAST = l; S_TID = id; S_TDEST = dst; S_TUSER = u;
        S_TSTRB = 4'hF; S_TKEEP = 4'hF;
    endtask

    function automatic logic [31:0] rdat(input int n);
        return 32'hD000_0000 ^ (32'(n) * 32'h0001_0003);
    endfunction

    function automatic logic rlast(input int n);
        return ((n % 3) == 2) || (n == 999);
    endfunction

    initial begin
        int sent, rcvd, lvl, cyc, idx;
        logic do_push, do_pop;

        ARESETn = 1'b1; S_TVALID = 1'b0; M_TREADY = 1'b0;
        set_beat(32'h0, 1'b0, 4'h0, 4'h0, 8'h0);
        #2 ARESETn = 1'b0;
        step(); step();
        chk("rst_mvalid", M_TVALID, 0);
        chk("rst_sready", S_TREADY, 0);
        chk("rst_level", LEVEL, 0);
        chk("rst_mdata", M_TDATA, 0);
        ARESETn = 1'b1;
        step();
        chk("rel_sready", S_TREADY, 1);

        // single beat
        set_beat(32'hA5A5_0001, 1'b1, 4'h3, 4'h2, 8'h5C);
        S_TVALID = 1'b1;
        step();
        S_TVALID = 1'b0;
        chk("single_mvalid", M_TVALID, 1);
        chk("single_fields", {M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER},
            {32'hA5A5_0001, 4'hF, 4'hF, 1'b1, 4'h3, 4'h2, 8'h5C});
        chk("single_level", LEVEL, 1);
        M_TREADY = 1'b1;
        step();
        M_TREADY = 1'b0;
        chk("single_pop_level", LEVEL, 0);
        chk("single_pop_mvalid", M_TVALID, 0);

        // fill with 0..7 while stalled
        for (int i = 0; i < 8; i++) begin
            set_beat(32'(i), 1'b0, 4'(i), 4'h0, 8'(i));
            S_TVALID = 1'b1;
            step();
        end
        S_TVALID = 1'b0;
        chk("fill_sready", S_TREADY, 0);
        chk("fill_level", LEVEL, 8);
        for (int i = 0; i < 20; i++) begin
            chk("stall_mdata", M_TDATA, 0);
            chk("stall_mvalid", M_TVALID, 1);
            step();
        end

        // full: one pop, blocked push, then push lands
        set_beat(32'h8, 1'b1, 4'h8, 4'h0, 8'h8);
        S_TVALID = 1'b1;
        M_TREADY = 1'b1;
        step();
        M_TREADY = 1'b0;
        chk("fullpop_sready", S_TREADY, 1);
        chk("fullpop_level", LEVEL, 7);
        chk("fullpop_mdata", M_TDATA, 1);
        step();
        S_TVALID = 1'b0;
        chk("refill_level", LEVEL, 8);
        chk("refill_sready", S_TREADY, 0);
        M_TREADY = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk("drain_mvalid", M_TVALID, 1);
            chk("drain_mdata", M_TDATA, 32'(k));
            step();
        end
        M_TREADY = 1'b0;
        chk("drain_level", LEVEL, 0);

        // random traffic: 1000 beats in order
        sent = 0; rcvd = 0; lvl = 0; cyc = 0;
        while (rcvd < 1000 && cyc < 20000) begin
            S_TVALID = (sent < 1000) && ($urandom_range(0, 3) != 0);
            set_beat(rdat(sent), rlast(sent), 4'(sent), 4'(sent >> 4), 8'(sent));
            M_TREADY = ($urandom_range(0, 2) != 0);
            do_push = S_TVALID && S_TREADY;
            do_pop  = M_TVALID && M_TREADY;
            if (do_pop)
                chk("rand_beat", {M_TDATA, M_TLAST, M_TID, M_TDEST, M_TUSER},
                    {rdat(rcvd), rlast(rcvd), 4'(rcvd), 4'(rcvd >> 4), 8'(rcvd)});
            step();
            sent += int'(do_push);
            rcvd += int'(do_pop);
            lvl  += int'(do_push) - int'(do_pop);
            chk("rand_level", LEVEL, 64'(lvl));
            cyc++;
        end
        S_TVALID = 1'b0; M_TREADY = 1'b0;
        chk("rand_done", 64'(rcvd), 1000);

        // reset with five beats stored
        for (int i = 0; i < 5; i++) begin
            set_beat(32'(100 + i), 1'b0, 4'h1, 4'h1, 8'h1);
            S_TVALID = 1'b1;
            step();
        end
        S_TVALID = 1'b0;
        chk("mid_level", LEVEL, 5);
        #2 ARESETn = 1'b0;
        #1;
        chk("async_mvalid", M_TVALID, 0);
        chk("async_sready", S_TREADY, 0);
        chk("async_level", LEVEL, 0);
        chk("async_mdata", M_TDATA, 0);
        step();
        ARESETn = 1'b1;
        step();
        chk("post_level", LEVEL, 0);
        chk("post_sready", S_TREADY, 1);
        set_beat(32'hCAFE_0001, 1'b1, 4'h7, 4'h6, 8'h77);
        S_TVALID = 1'b1;
        step();
        S_TVALID = 1'b0;
        chk("post_mvalid", M_TVALID, 1);
        chk("post_mdata", M_TDATA, 32'hCAFE_0001);
        M_TREADY = 1'b1;
        step();
        M_TREADY = 1'b0;
        chk("post_drain", LEVEL, 0);

`ifdef AXIS_FIFO_PACKET_MODE_EN
        // store-and-forward: 3-beat packet
        for (int i = 0; i < 3; i++) begin
            set_beat(32'(32'h300 + i), (i == 2), 4'h2, 4'h2, 8'h2);
            S_TVALID = 1'b1;
            step();
            chk("pkt3_hold", M_TVALID, (i == 2));
        end
        S_TVALID = 1'b0;
        M_TREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("pkt3_mvalid", M_TVALID, 1);
            chk("pkt3_mdata", M_TDATA, 32'(32'h300 + i));
            step();
        end
        M_TREADY = 1'b0;
        chk("pkt3_level", LEVEL, 0);

        // oversized 10-beat packet released through the full escape
        idx = 0; rcvd = 0; cyc = 0;
        M_TREADY = 1'b1;
        while (rcvd < 10 && cyc < 200) begin
            S_TVALID = (idx < 10);
            set_beat(32'(32'h400 + idx), (idx == 9), 4'h4, 4'h4, 8'h4);
            do_push = S_TVALID && S_TREADY;
            do_pop  = M_TVALID && M_TREADY;
            if (rcvd == 0 && LEVEL < 8) chk("pkt10_hold", M_TVALID, 0);
            if (do_pop) begin
                if (rcvd == 0) chk("pkt10_start_level", LEVEL, 8);
                chk("pkt10_mdata", M_TDATA, 32'(32'h400 + rcvd));
            end
            step();
            idx  += int'(do_push);
            rcvd += int'(do_pop);
            cyc++;
        end
        S_TVALID = 1'b0; M_TREADY = 1'b0;
        chk("pkt10_done", 64'(rcvd), 10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
